// File: rtl/load_store_unit_if.sv
// Request/response and byte-memory bus of the load/store unit.
// The slave modport is the unit itself; master is its environment (CPU plus memory).
interface load_store_unit_if #(
    parameter int ADDR_WIDTH = 6
);
    logic                  reqValid;
    logic                  reqReady;
    logic                  reqWrite;
    logic [31:0]           reqAddress;
    logic [2:0]            reqType;
    logic [31:0]           reqData;
    logic                  rspValid;
    logic [31:0]           rspData;
    logic                  rspError;
    logic [ADDR_WIDTH-1:0] memAddress;
    logic                  memRead;
    logic                  memWrite;
    logic [7:0]            memWriteData;
    logic [7:0]            memReadData;

    modport slave (
        input  reqValid, reqWrite, reqAddress, reqType, reqData, memReadData,
        output reqReady, rspValid, rspData, rspError,
        output memAddress, memRead, memWrite, memWriteData
    );

    modport master (
        output reqValid, reqWrite, reqAddress, reqType, reqData, memReadData,
        input  reqReady, rspValid, rspData, rspError,
        input  memAddress, memRead, memWrite, memWriteData
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: splits word/half/byte requests into little-endian byte
// transactions on a byte-wide synchronous memory and reassembles load results.
module load_store_unit #(
    parameter int ADDR_WIDTH  = 6,
    parameter bit CHECK_ALIGN = 1'b1
) (
    input logic               clk,
    input logic               rst,
    load_store_unit_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t                state_r;
    logic [1:0]            k_r;
    logic [1:0]            last_r;
    logic                  write_r;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [2:0]            type_r;
    logic [31:0]           data_r;
    logic [31:0]           asm_r;

    logic                  rsp_valid_r;
    logic                  rsp_error_r;
    logic [31:0]           rsp_data_r;
    logic [ADDR_WIDTH-1:0] mem_addr_r;
    logic                  mem_read_r;
    logic                  mem_write_r;
    logic [7:0]            mem_wdata_r;

    logic [1:0]            req_last_s;
    logic [32:0]           req_span_s;
    logic                  req_err_s;
    logic [1:0]            k_next_s;
    logic [1:0]            k_prev_s;
    logic [31:0]           final_word_s;

    // Index of the last byte (N-1) for a request type; illegal types map to 0.
    function automatic logic [1:0] last_index(input logic [2:0] t);
        logic [1:0] r;
        case (t)
            3'b000:  r = 2'd3;
            3'b001:  r = 2'd1;
            3'b010:  r = 2'd1;
            default: r = 2'd0;
        endcase
        return r;
    endfunction

    // Sign or zero extension of the assembled load word.
    function automatic logic [31:0] extend_load(input logic [2:0] t, input logic [31:0] w);
        logic [31:0] r;
        case (t)
            3'b001:  r = {{16{w[15]}}, w[15:0]};
            3'b010:  r = {16'h0000, w[15:0]};
            3'b011:  r = {{24{w[7]}}, w[7:0]};
            3'b100:  r = {24'h000000, w[7:0]};
            default: r = w;
        endcase
        return r;
    endfunction

    // Request classification: the end address is formed in 33 bits so a high address cannot wrap into range.
    always_comb begin
        req_last_s = last_index(bus.reqType);
        req_span_s = {1'b0, bus.reqAddress} + {31'd0, req_last_s};
        req_err_s  = 1'b0;
        if (bus.reqType > 3'd4) begin
            req_err_s = 1'b1;
        end else if ((req_span_s >> ADDR_WIDTH) != 33'd0) begin
            req_err_s = 1'b1;
        end else if (CHECK_ALIGN && (bus.reqType == 3'b000) && (bus.reqAddress[1:0] != 2'b00)) begin
            req_err_s = 1'b1;
        end else if (CHECK_ALIGN && ((bus.reqType == 3'b001) || (bus.reqType == 3'b010))
                     && bus.reqAddress[0]) begin
            req_err_s = 1'b1;
        end else begin
            req_err_s = 1'b0;
        end
    end

    // Byte-index helpers and the load word with the final returning byte merged in.
    always_comb begin
        k_next_s     = k_r + 2'd1;
        k_prev_s     = k_r - 2'd1;
        final_word_s = asm_r;
        final_word_s[{last_r, 3'b000} +: 8] = bus.memReadData;
    end

    // Main FSM with registered response and memory strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= S_IDLE;
            k_r         <= 2'd0;
            last_r      <= 2'd0;
            write_r     <= 1'b0;
            addr_r      <= '0;
            type_r      <= 3'd0;
            data_r      <= 32'd0;
            asm_r       <= 32'd0;
            rsp_valid_r <= 1'b0;
            rsp_error_r <= 1'b0;
            rsp_data_r  <= 32'd0;
            mem_addr_r  <= '0;
            mem_read_r  <= 1'b0;
            mem_write_r <= 1'b0;
            mem_wdata_r <= 8'd0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    rsp_valid_r <= 1'b0;
                    rsp_error_r <= 1'b0;
                    rsp_data_r  <= 32'd0;
                    if (bus.reqValid) begin
                        write_r <= bus.reqWrite;
                        addr_r  <= bus.reqAddress[ADDR_WIDTH-1:0];
                        type_r  <= bus.reqType;
                        data_r  <= bus.reqData;
                        last_r  <= req_last_s;
                        k_r     <= 2'd0;
                        asm_r   <= 32'd0;
                        if (req_err_s) begin
                            state_r     <= S_RESP;
                            rsp_valid_r <= 1'b1;
                            rsp_error_r <= 1'b1;
                        end else begin
                            state_r     <= S_ISSUE;
                            mem_addr_r  <= bus.reqAddress[ADDR_WIDTH-1:0];
                            mem_write_r <= bus.reqWrite;
                            mem_read_r  <= ~bus.reqWrite;
                            mem_wdata_r <= bus.reqWrite ? bus.reqData[7:0] : 8'd0;
                        end
                    end
                end
                S_ISSUE: begin
                    // Read data lags its strobe by one cycle, so this cycle delivers byte k-1.
                    if (!write_r && (k_r != 2'd0)) begin
                        asm_r[{k_prev_s, 3'b000} +: 8] <= bus.memReadData;
                    end
                    if (k_r == last_r) begin
                        mem_read_r  <= 1'b0;
                        mem_write_r <= 1'b0;
                        mem_wdata_r <= 8'd0;
                        if (write_r) begin
                            state_r     <= S_RESP;
                            rsp_valid_r <= 1'b1;
                            rsp_data_r  <= 32'd0;
                        end else begin
                            state_r <= S_DRAIN;
                        end
                    end else begin
                        k_r         <= k_next_s;
                        mem_addr_r  <= addr_r + {{(ADDR_WIDTH-2){1'b0}}, k_next_s};
                        mem_wdata_r <= write_r ? data_r[{k_next_s, 3'b000} +: 8] : 8'd0;
                    end
                end
                S_DRAIN: begin
                    asm_r       <= final_word_s;
                    rsp_valid_r <= 1'b1;
                    rsp_error_r <= 1'b0;
                    rsp_data_r  <= extend_load(type_r, final_word_s);
                    state_r     <= S_RESP;
                end
                S_RESP: begin
                    rsp_valid_r <= 1'b0;
                    rsp_error_r <= 1'b0;
                    rsp_data_r  <= 32'd0;
                    k_r         <= 2'd0;
                    state_r     <= S_IDLE;
                end
                default: begin
                    state_r     <= S_IDLE;
                    k_r         <= 2'd0;
                    rsp_valid_r <= 1'b0;
                    rsp_error_r <= 1'b0;
                    rsp_data_r  <= 32'd0;
                    mem_read_r  <= 1'b0;
                    mem_write_r <= 1'b0;
                    mem_wdata_r <= 8'd0;
                end
            endcase
        end
    end

    // Ready is gated by rst so it reads 0 throughout the reset cycle and 1 as soon as rst drops.
    assign bus.reqReady     = (state_r == S_IDLE) && !rst;
    assign bus.rspValid     = rsp_valid_r;
    assign bus.rspError     = rsp_error_r;
    assign bus.rspData      = rsp_data_r;
    assign bus.memAddress   = mem_addr_r;
    assign bus.memRead      = mem_read_r;
    assign bus.memWrite     = mem_write_r;
    assign bus.memWriteData = mem_wdata_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed, table-driven bench for load_store_unit with a byte-wide memory model.
module tb_load_store_unit;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    load_store_unit_if #(.ADDR_WIDTH(6)) bus ();

    load_store_unit #(.ADDR_WIDTH(6), .CHECK_ALIGN(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0] mem [64];

    // Synchronous byte memory: read data appears the cycle after memRead.
    always @(posedge clk) begin
        if (bus.memWrite) mem[bus.memAddress] <= bus.memWriteData;
        if (bus.memRead)  bus.memReadData <= mem[bus.memAddress];
    end

    typedef struct {
        string       name;
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  typ;
        logic [31:0] data;
        logic [31:0] exp_data;
        logic        exp_err;
        int          exp_lat;
        int          exp_n;
    } vec_t;

    vec_t vecs[$];
    int passed = 0;
    int total  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic add(input string nm, input logic wr, input logic [31:0] addr, input logic [2:0] typ,
                       input logic [31:0] data, input logic [31:0] exp_data, input logic exp_err,
                       input int exp_lat, input int exp_n);
        vec_t v;
        v.name = nm; v.wr = wr; v.addr = addr; v.typ = typ; v.data = data;
        v.exp_data = exp_data; v.exp_err = exp_err; v.exp_lat = exp_lat; v.exp_n = exp_n;
        vecs.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input vec_t v);
        bus.reqValid   = 1'b1;
        bus.reqWrite   = v.wr;
        bus.reqAddress = v.addr;
        bus.reqType    = v.typ;
        bus.reqData    = v.data;
    endtask

    task automatic wait_ready(input string nm);
        int w;
        w = 0;
        while (!bus.reqReady && w < 8) begin
            tick();
            w++;
        end
        chk({nm, "_ready"}, {31'd0, bus.reqReady}, 32'd1);
    endtask

    // Issues one request (cycle C0) and checks strobes, response timing and contents.
    task automatic run_req(input vec_t v);
        int  c, n, bad;
        bit  got;
        wait_ready(v.name);
        drive_req(v);
        tick();
        bus.reqValid = 1'b0;
        c = 1; n = 0; bad = 0; got = 1'b0;
        while (!got && c <= 12) begin
            if (bus.memRead && bus.memWrite) bad++;
            if (bus.memRead || bus.memWrite) begin
                if (bus.memAddress !== 6'(v.addr + 32'(n))) bad++;
                if (bus.memWrite !== v.wr) bad++;
                if (v.wr && n < 4 && bus.memWriteData !== v.data[8*n +: 8]) bad++;
                n++;
            end
            if (bus.rspValid) begin
                got = 1'b1;
                chk({v.name, "_data"}, bus.rspData, v.exp_data);
                chk({v.name, "_err"}, {31'd0, bus.rspError}, {31'd0, v.exp_err});
                chk({v.name, "_lat"}, 32'(c), 32'(v.exp_lat));
            end else begin
                tick();
                c++;
            end
        end
        chk({v.name, "_rsp_seen"}, {31'd0, got}, 32'd1);
        chk({v.name, "_strobes"}, 32'(n), 32'(v.exp_n));
        chk({v.name, "_seq"}, 32'(bad), 32'd0);
        tick();
        chk({v.name, "_pulse"}, {31'd0, bus.rspValid}, 32'd0);
        chk({v.name, "_ready_after"}, {31'd0, bus.reqReady}, 32'd1);
    endtask

    initial begin
        vec_t v;
        int   strobes;
        int   rsps;

        add("st_w8",     1'b1, 32'd8,          3'b000, 32'h11223344, 32'h00000000, 1'b0, 5, 4);
        add("ld_w8",     1'b0, 32'd8,          3'b000, 32'h0,        32'h11223344, 1'b0, 6, 4);
        add("st_b12",    1'b1, 32'd12,         3'b011, 32'hCAFE0080, 32'h00000000, 1'b0, 2, 1);
        add("ld_b12",    1'b0, 32'd12,         3'b011, 32'h0,        32'hFFFFFF80, 1'b0, 3, 1);
        add("ld_bu12",   1'b0, 32'd12,         3'b100, 32'h0,        32'h00000080, 1'b0, 3, 1);
        add("st_h14",    1'b1, 32'd14,         3'b001, 32'h77779122, 32'h00000000, 1'b0, 3, 2);
        add("ld_h14",    1'b0, 32'd14,         3'b001, 32'h0,        32'hFFFF9122, 1'b0, 4, 2);
        add("ld_hu14",   1'b0, 32'd14,         3'b010, 32'h0,        32'h00009122, 1'b0, 4, 2);
        add("err_mis6",  1'b0, 32'd6,          3'b000, 32'h0,        32'h00000000, 1'b1, 1, 0);
        add("err_type5", 1'b0, 32'd0,          3'b101, 32'h0,        32'h00000000, 1'b1, 1, 0);
        add("err_st62",  1'b1, 32'd62,         3'b000, 32'hDEADBEEF, 32'h00000000, 1'b1, 1, 0);
        add("err_b40",   1'b0, 32'h40,         3'b011, 32'h0,        32'h00000000, 1'b1, 1, 0);
        add("err_h13",   1'b0, 32'd13,         3'b001, 32'h0,        32'h00000000, 1'b1, 1, 0);
        add("err_wrap",  1'b0, 32'hFFFFFFFC,   3'b000, 32'h0,        32'h00000000, 1'b1, 1, 0);
        add("st_b63",    1'b1, 32'd63,         3'b100, 32'h0000005A, 32'h00000000, 1'b0, 2, 1);
        add("ld_bu63",   1'b0, 32'd63,         3'b100, 32'h0,        32'h0000005A, 1'b0, 3, 1);
        add("st_hu62",   1'b1, 32'd62,         3'b010, 32'h1234BEEF, 32'h00000000, 1'b0, 3, 2);
        add("ld_h62",    1'b0, 32'd62,         3'b001, 32'h0,        32'hFFFFBEEF, 1'b0, 4, 2);

        rst = 1'b1;
        bus.reqValid = 1'b0; bus.reqWrite = 1'b0; bus.reqAddress = 32'd0;
        bus.reqType = 3'd0; bus.reqData = 32'd0;
        tick();
        tick();
        chk("rst_ready",  {31'd0, bus.reqReady},  32'd0);
        chk("rst_rspv",   {31'd0, bus.rspValid},  32'd0);
        chk("rst_rspd",   bus.rspData,            32'd0);
        chk("rst_rspe",   {31'd0, bus.rspError},  32'd0);
        chk("rst_maddr",  {26'd0, bus.memAddress}, 32'd0);
        chk("rst_strobe", {30'd0, bus.memRead, bus.memWrite}, 32'd0);
        chk("rst_wdata",  {24'd0, bus.memWriteData}, 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_ready_after", {31'd0, bus.reqReady}, 32'd1);

        foreach (vecs[i]) run_req(vecs[i]);

        // Reset during C2 of a word store: bytes 8-9 written, 10-11 keep 0x22/0x11.
        v.name = "rst_st"; v.wr = 1'b1; v.addr = 32'd8; v.typ = 3'b000; v.data = 32'h55667788;
        wait_ready("rst_st");
        drive_req(v);
        tick();
        bus.reqValid = 1'b0;
        chk("mid_c1_write", {31'd0, bus.memWrite}, 32'd1);
        tick();
        chk("mid_c2_write", {31'd0, bus.memWrite}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("mid_c3_strobe", {30'd0, bus.memRead, bus.memWrite}, 32'd0);
        chk("mid_c3_ready", {31'd0, bus.reqReady}, 32'd1);
        strobes = 0; rsps = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus.memRead || bus.memWrite) strobes++;
            if (bus.rspValid) rsps++;
            tick();
        end
        chk("mid_no_strobe", 32'(strobes), 32'd0);
        chk("mid_no_rsp", 32'(rsps), 32'd0);

        v.name = "ld_after_rst"; v.wr = 1'b0; v.addr = 32'd8; v.typ = 3'b000; v.data = 32'h0;
        v.exp_data = 32'h11227788; v.exp_err = 1'b0; v.exp_lat = 6; v.exp_n = 4;
        run_req(v);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-access initiator between the CPU execute stage and a byte-wide synchronous data memory. It accepts one load or store request at a time through a valid/ready handshake. Each request is split into 1, 2 or 4 sequential byte transactions at little-endian ascending addresses. Load bytes are reassembled with sign or zero extension, and misaligned, out-of-range and illegal-type requests are rejected without touching memory.

## Interface
- ADDR_WIDTH, 6, memory byte-address width; the memory holds 2^ADDR_WIDTH bytes.
- CHECK_ALIGN, 1, when 1, misaligned half/word requests are errors; when 0, they are performed bytewise.

- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- reqValid  in  1  request present.
- reqReady  out  1  unit can accept a request; high only in IDLE.
- reqWrite  in  1  1 = store, 0 = load.
- reqAddress  in  32  byte address from the ALU.
- reqType  in  3  000 word, 001 half, 010 half unsigned, 011 byte, 100 byte unsigned; 101-111 illegal.
- reqData  in  32  store data; the low N bytes are used.
- rspValid  out  1  one-cycle completion pulse, with no backpressure.
- rspData  out  32  extended load result; 0 for stores and errors.
- rspError  out  1  valid with rspValid; 1 = request rejected.
- memAddress  out  ADDR_WIDTH  byte address for the current transaction.
- memRead  out  1  read strobe.
- memWrite  out  1  write strobe.
- memWriteData  out  8  byte to write.
- memReadData  in  8  byte returned one cycle after memRead is sampled.

## Operation
- FSM states: IDLE, ISSUE, DRAIN, RESP.
- IDLE: when reqValid && reqReady, latch the whole request and the byte count N.
  - N is 4 for word, 2 for half/half unsigned, 1 for byte/byte unsigned.
  - If the request is an error, go to RESP with rspError=1.
  - Otherwise clear byte counter k and go to ISSUE.
- Error conditions:
  - reqType is illegal.
  - reqAddress + N - 1 >= 2^ADDR_WIDTH, computed in 33 bits with no wrap.
  - CHECK_ALIGN=1 and the address is misaligned: word needs addr[1:0]=0, half needs addr[0]=0.
- ISSUE, one byte per cycle:
  - memAddress = latched address + k.
  - Store: memWrite=1, memWriteData = reqData byte k.
  - Load: memRead=1.
  - On k=N-1, a store goes to RESP and a load goes to DRAIN.
- Load capture: the byte returned for index k is written into assembly byte lane k on the cycle after it is issued.
- DRAIN: capture the final byte, then go to RESP.
- Extension, applied when entering RESP:
  - Signed byte/half: replicate bit 7 / bit 15 upward.
  - Unsigned types: zero-fill.
  - Word: no extension.
- RESP: rspValid=1 for one cycle, then go to IDLE.
- memRead and memWrite are never both high. Both are 0 outside ISSUE.
- reqValid outside IDLE is ignored; the requester must hold the request until it sees reqReady.

## Timing
- Let C0 be the cycle in which the handshake fires.
- Store: memWrite is high in C1..CN; rspValid in C(N+1). Word store: 5 cycles from accept to response.
- Load: memRead is high in C1..CN; the last byte is captured at the end of C(N+1); rspValid in C(N+2). Word load: 6 cycles.
- Error: no memory strobes; rspValid with rspError=1 in C1.
- reqReady returns high in the cycle after RESP. Back-to-back requests therefore take 1 idle cycle of accept opportunity after each response.
- Reset values:
  - State is IDLE and k=0.
  - All outputs are 0 during the reset cycle: reqReady, rspValid, rspData, rspError, memAddress, memRead, memWrite, memWriteData.
  - reqReady is 1 in the first cycle after rst deasserts.
- Reset mid-operation: the request is abandoned and strobes are 0 from the cycle after rst is sampled. No response is issued. Bytes already written stay written; there is no rollback.
- Address arithmetic is unsigned. k never exceeds N-1, so memAddress never wraps for an accepted, non-error request.

## Test plan
- Store word 0x11223344 at address 8 -> memWrite in C1..C4 at addresses 8, 9, 10, 11 with data 0x44, 0x33, 0x22, 0x11; rspValid in C5; rspError=0; rspData=0.
- Then load word at address 8 -> memRead in C1..C4; rspValid in C6; rspData=0x11223344.
- Memory byte 12 = 0x80: signed byte load at 12 -> rspData 0xFFFFFF80 in C3; unsigned byte load -> 0x00000080.
- Bytes 14 = 0x22 and 15 = 0x91: signed half load at 14 -> 0xFFFF9122 in C4; unsigned half load -> 0x00009122.
- Errors: each of the following gives rspValid with rspError=1, rspData=0 in C1, and no strobes.
  - Word load at address 6 with CHECK_ALIGN=1.
  - Type 101 at address 0.
  - Word store at address 62.
  - Byte load at address 0x40.
- rst asserted in C2 of a word store to address 8 -> strobes 0 from C3 and no rspValid; bytes 8-9 updated, bytes 10-11 unchanged; reqReady=1 in the cycle after rst deasserts.
